// File: rtl/mnist_frame_streamer.sv
// rtl/mnist_frame_streamer.sv - raster-order frame source from image RAM onto a valid/ready pixel stream
module mnist_frame_streamer #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 10
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iStart,
  input  logic [ADDR_W-1:0]        iBaseAddr,
  output logic                     oBusy,
  output logic                     oDone,
  output logic [15:0]              oFrameCnt,
  output logic                     oMemRdEn,
  output logic [ADDR_W-1:0]        oMemAddr,
  input  logic [PIX_W-1:0]         iMemRdData,
  output logic [PIX_W-1:0]         oPixelOut,
  output logic                     oPixelValid,
  input  logic                     iReady,
  output logic [$clog2(IMG_H)-1:0] oRow,
  output logic [$clog2(IMG_W)-1:0] oCol,
  output logic                     oWindowValid,
  output logic                     oPixelLast
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam int FW    = PIX_W + ROW_W + COL_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_addr;
  logic [ROW_W-1:0]   r_rd_row, r_infl_row;
  logic [COL_W-1:0]   r_rd_col, r_infl_col;
  logic               r_infl, r_infl_last;
  logic [FW-1:0]      r_fifo [2];
  logic               r_wptr, r_rptr;
  logic [1:0]         r_cnt;
  logic [15:0]        r_frame_cnt;

  logic               w_pop, w_issue, w_rd_last, w_valid;
  logic [2:0]         w_occ;
  logic [FW-1:0]      w_head;
  logic [ROW_W-1:0]   w_head_row;
  logic [COL_W-1:0]   w_head_col;

  // Occupancy seen by the next cycle: buffered beats plus the read landing now, minus today's pop.
  assign w_valid   = (r_cnt != 2'd0);
  assign w_pop     = w_valid & iReady;
  assign w_occ     = 3'(r_cnt) + 3'(r_infl) - 3'(w_pop);
  assign w_issue   = (r_state == S_STREAM) && (w_occ < 3'd2);
  assign w_rd_last = (r_rd_row == ROW_W'(IMG_H - 1)) && (r_rd_col == COL_W'(IMG_W - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (iStart) w_state_nxt = S_STREAM;
      S_STREAM: if (w_issue && w_rd_last) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (w_occ == 3'd0) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rd_row    <= '0;
      r_rd_col    <= '0;
      r_infl      <= 1'b0;
      r_infl_row  <= '0;
      r_infl_col  <= '0;
      r_infl_last <= 1'b0;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_cnt       <= 2'd0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && iStart) begin
        r_addr   <= iBaseAddr;
        r_rd_row <= '0;
        r_rd_col <= '0;
      end else if (w_issue) begin
        r_addr <= r_addr + ADDR_W'(1);
        if (r_rd_col == COL_W'(IMG_W - 1)) begin
          r_rd_col <= '0;
          r_rd_row <= r_rd_row + ROW_W'(1);
        end else begin
          r_rd_col <= r_rd_col + COL_W'(1);
        end
      end
      // Tags ride alongside the read so they meet the RAM data one cycle later.
      r_infl <= w_issue;
      if (w_issue) begin
        r_infl_row  <= r_rd_row;
        r_infl_col  <= r_rd_col;
        r_infl_last <= w_rd_last;
      end
      if (r_infl) begin
        r_fifo[r_wptr] <= {iMemRdData, r_infl_row, r_infl_col, r_infl_last};
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + 2'(r_infl) - 2'(w_pop);
      if (r_state == S_DONE) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign w_head     = r_fifo[r_rptr];
  assign w_head_row = w_head[COL_W+ROW_W:COL_W+1];
  assign w_head_col = w_head[COL_W:1];

  assign oBusy        = (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign oDone        = (r_state == S_DONE);
  assign oFrameCnt    = r_frame_cnt;
  assign oMemRdEn     = w_issue;
  assign oMemAddr     = r_addr;
  assign oPixelValid  = w_valid;
  assign oPixelOut    = w_valid ? w_head[FW-1 -: PIX_W] : '0;
  assign oRow         = w_valid ? w_head_row : '0;
  assign oCol         = w_valid ? w_head_col : '0;
  assign oPixelLast   = w_valid & w_head[0];
  assign oWindowValid = w_valid && (w_head_row >= ROW_W'(2)) && (w_head_col >= COL_W'(2));

endmodule

// File: tb/tb_mnist_frame_streamer.sv
// tb/tb_mnist_frame_streamer.sv - scoreboard bench for mnist_frame_streamer
module tb_mnist_frame_streamer;

  localparam int N = 784;

  logic        iClk = 1'b0;
  logic        iRst, iStart, iReady;
  logic [9:0]  iBaseAddr;
  logic        oBusy, oDone, oMemRdEn, oPixelValid, oWindowValid, oPixelLast;
  logic [15:0] oFrameCnt;
  logic [9:0]  oMemAddr;
  logic [7:0]  iMemRdData, oPixelOut;
  logic [4:0]  oRow, oCol;

  mnist_frame_streamer dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iBaseAddr(iBaseAddr),
    .oBusy(oBusy), .oDone(oDone), .oFrameCnt(oFrameCnt),
    .oMemRdEn(oMemRdEn), .oMemAddr(oMemAddr), .iMemRdData(iMemRdData),
    .oPixelOut(oPixelOut), .oPixelValid(oPixelValid), .iReady(iReady),
    .oRow(oRow), .oCol(oCol), .oWindowValid(oWindowValid), .oPixelLast(oPixelLast)
  );

  always #5 iClk = ~iClk;

  logic [7:0] ram [1024];
  always @(posedge iClk) if (oMemRdEn) iMemRdData <= ram[oMemAddr];

  typedef struct packed {
    logic [7:0] pix;
    logic [4:0] row;
    logic [4:0] col;
    logic       last;
    logic       wv;
  } exp_t;

  typedef struct {
    int base;
    bit bp;
    bit busy_start;
    bit abort;
    int exp_wv;
    int exp_first_wv;
    int exp_last_beat;
  } vec_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, cur_base, rd_k, beats, s_cnt, wv_cnt, first_wv, last_cnt, last_beat;
  int   first_vcyc, done_cyc, exp_fc;
  bit   got_done, prev_stall;
  logic [19:0] prev_head;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (oMemRdEn) begin
      chk("rd_addr", oMemAddr, (cur_base + rd_k) % 1024);
      chk("rd_while_busy", oBusy, 1);
      rd_k++;
    end
    if (oPixelValid && first_vcyc < 0) first_vcyc = cyc;
    if (prev_stall && oPixelValid)
      chk("stall_hold", {oPixelOut, oRow, oCol, oPixelLast, oWindowValid}, prev_head);
    if (oPixelValid && !iReady) s_cnt++;
    if (oPixelValid && iReady) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {oPixelOut, oRow, oCol, oPixelLast, oWindowValid}, e);
      end
      if (oWindowValid) begin
        wv_cnt++;
        if (first_wv < 0) first_wv = beats;
      end
      if (oPixelLast) begin
        last_cnt++;
        last_beat = beats;
      end
      beats++;
    end
    if (oBusy) chk("buffered_le2", ((rd_k - beats) <= 2), 1);
    prev_stall = oPixelValid && !iReady;
    prev_head  = {oPixelOut, oRow, oCol, oPixelLast, oWindowValid};
    if (oDone && !got_done) begin
      got_done = 1'b1;
      done_cyc = cyc;
      chk("busy_at_done", oBusy, 0);
    end
  endtask

  task automatic step();
    cyc++;
    @(negedge iClk);
    monitor();
    @(posedge iClk);
    #1;
  endtask

  task automatic run_frame(input vec_t v);
    exp_t e;
    int   t0, budget;
    bit   poked;
    exp_q.delete();
    cur_base = v.base; rd_k = 0; beats = 0; s_cnt = 0; wv_cnt = 0; first_wv = -1;
    last_cnt = 0; last_beat = -1; first_vcyc = -1; got_done = 0; done_cyc = -1;
    prev_stall = 0; poked = 0;
    for (int k = 0; k < N; k++) begin
      e.pix  = 8'((v.base + k) % 1024);
      e.row  = 5'(k / 28);
      e.col  = 5'(k % 28);
      e.last = (k == N - 1);
      e.wv   = ((k / 28) >= 2) && ((k % 28) >= 2);
      exp_q.push_back(e);
    end
    iStart    = 1'b1;
    iBaseAddr = 10'(v.base);
    iReady    = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
    step();
    t0     = cyc;
    iStart = 1'b0;
    chk("busy_rden_T1", {oBusy, oMemRdEn}, 2'b11);
    budget = 0;
    while (!got_done && budget < 5000) begin
      iBaseAddr = 10'($urandom);
      iReady    = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v.busy_start && !poked && beats == 100) begin
        iStart    = 1'b1;
        iBaseAddr = 10'd512;
        poked     = 1'b1;
      end
      if (v.abort && beats >= 300) begin
        iRst = 1'b1;
        step();
        iRst = 1'b0;
        chk("abort_outs_zero", {oBusy, oDone, oFrameCnt, oMemRdEn, oMemAddr, oPixelOut,
                                oPixelValid, oRow, oCol, oWindowValid, oPixelLast}, 0);
        for (int i = 0; i < 3; i++) begin
          step();
          chk("abort_quiet", {oMemRdEn, oPixelValid, oBusy}, 0);
        end
        exp_q.delete();
        prev_stall = 1'b0;
        exp_fc     = 0;
        return;
      end
      step();
      iStart = 1'b0;
      budget++;
    end
    if (!got_done) chk("done_timeout", 0, 1);
    exp_fc++;
    chk("beats", beats, N);
    chk("sb_left", exp_q.size(), 0);
    chk("reads", rd_k, N);
    chk("first_valid_cyc", first_vcyc, t0 + 3);
    chk("done_cyc", done_cyc, t0 + 3 + N + s_cnt);
    chk("last_cnt", last_cnt, 1);
    chk("last_beat", last_beat, v.exp_last_beat);
    chk("wv_cnt", wv_cnt, v.exp_wv);
    chk("first_wv", first_wv, v.exp_first_wv);
    chk("frame_cnt", oFrameCnt, exp_fc);
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{base: 0,    bp: 0, busy_start: 0, abort: 0, exp_wv: 676, exp_first_wv: 58, exp_last_beat: 783};
    vecs[1] = '{base: 0,    bp: 1, busy_start: 0, abort: 0, exp_wv: 676, exp_first_wv: 58, exp_last_beat: 783};
    vecs[2] = '{base: 1000, bp: 0, busy_start: 0, abort: 0, exp_wv: 676, exp_first_wv: 58, exp_last_beat: 783};
    vecs[3] = '{base: 0,    bp: 0, busy_start: 1, abort: 0, exp_wv: 676, exp_first_wv: 58, exp_last_beat: 783};
    vecs[4] = '{base: 0,    bp: 1, busy_start: 0, abort: 1, exp_wv: 0,   exp_first_wv: 0,  exp_last_beat: 0};
    vecs[5] = '{base: 5,    bp: 1, busy_start: 0, abort: 0, exp_wv: 676, exp_first_wv: 58, exp_last_beat: 783};
    vecs[6] = '{base: 700,  bp: 0, busy_start: 0, abort: 0, exp_wv: 676, exp_first_wv: 58, exp_last_beat: 783};

    for (int i = 0; i < 1024; i++) ram[i] = 8'(i);
    exp_fc    = 0;
    iRst      = 1'b1;
    iStart    = 1'b0;
    iReady    = 1'b0;
    iBaseAddr = '0;
    @(posedge iClk);
    #1;
    for (int i = 0; i < 3; i++) step();
    chk("reset_outs_zero", {oBusy, oDone, oFrameCnt, oMemRdEn, oMemAddr, oPixelOut,
                            oPixelValid, oRow, oCol, oWindowValid, oPixelLast}, 0);
    iRst = 1'b0;
    iReady = 1'b1;
    step();
    chk("idle_no_read", {oMemRdEn, oBusy, oPixelValid}, 0);

    // Entries 5 and 6 run back to back: the second start lands in the cycle after oDone.
    foreach (vecs[i]) run_frame(vecs[i]);
    chk("final_frame_cnt", oFrameCnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mnist_frame_streamer.md
# mnist_frame_streamer

Frame source for the convolution front end. On a start pulse it reads one IMG_W×IMG_H image from a synchronous-read image RAM and streams it in raster order, one pixel per beat, over a valid/ready interface into the pixel input of the 3×3 sliding-window generator. Each pixel carries row/column tags, a window-complete flag and a last-pixel flag. In hardware it replaces the bench-side pixel feeder.

## Interface
- IMG_W, 28, pixels per row
- IMG_H, 28, rows per frame
- PIX_W, 8, pixel width
- ADDR_W, 10, image RAM address width (≥ clog2(IMG_W*IMG_H))
- iClk  in  1  clock, all logic on rising edge
- iRst  in  1  reset, synchronous, active-high
- iStart  in  1  one-cycle start request, honoured only in IDLE
- iBaseAddr  in  ADDR_W  first RAM address of the frame, latched with iStart
- oBusy  out  1  high from the cycle after accepted iStart until the cycle oDone asserts
- oDone  out  1  one-cycle pulse after the last pixel transfer
- oFrameCnt  out  16  frames completed, wraps at 2^16
- oMemRdEn  out  1  RAM read strobe
- oMemAddr  out  ADDR_W  RAM read address
- iMemRdData  in  PIX_W  RAM data, valid exactly one cycle after oMemRdEn
- oPixelOut  out  PIX_W  pixel data
- oPixelValid  out  1  beat valid
- iReady  in  1  downstream accepts the beat; transfer = oPixelValid & iReady
- oRow  out  clog2(IMG_H)  row index of the current beat
- oCol  out  clog2(IMG_W)  column index of the current beat
- oWindowValid  out  1  (oRow ≥ 2) & (oCol ≥ 2)
- oPixelLast  out  1  beat is pixel (IMG_H-1, IMG_W-1)

## Operation
- States: IDLE → STREAM → DRAIN → DONE → IDLE.
- IDLE: iStart=1 latches iBaseAddr, clears the read index, and moves to STREAM. iStart is ignored in all other states.
- STREAM: issue read k (k = 0…N-1, N = IMG_W*IMG_H) at oMemAddr = iBaseAddr + k, modulo 2^ADDR_W.
  - The tags travel with the read: row = k / IMG_W and col = k % IMG_W, held as incrementing counters with no divider.
  - After issuing read N-1, move to DRAIN.
- Output buffer: a 2-entry FIFO of {pixel, row, col, last}. The read issued in cycle t is written into the FIFO in cycle t+1.
- Credit rule: issue a read only if (fifo_count + reads_in_flight − pop_this_cycle) < 2. This gives no overflow and sustains 1 beat/cycle when iReady=1.
- oPixelOut, oRow, oCol, oWindowValid and oPixelLast come from the FIFO head. They stay stable while oPixelValid=1 and iReady=0.
- DRAIN: wait until the FIFO is empty with nothing in flight, then go to DONE.
- DONE: oDone=1 for one cycle, oFrameCnt increments, return to IDLE.
- iReady while oPixelValid=0 has no effect.
- Mid-frame iRst: abort immediately. No further beats or reads are issued, and the FIFO is flushed.

## Timing
- Reset values: every output is 0, the state is IDLE, and the FIFO is empty.
- With iStart accepted in cycle T and iReady held at 1:
  - oBusy=1 and first oMemRdEn in cycle T+1.
  - First oPixelValid in T+3, then one beat per cycle through T+2+N.
  - oPixelLast in T+2+N.
  - oDone in T+3+N, with oBusy=0 in that same cycle.
- With iReady=0 for S cycles mid-frame: at most 2 beats are buffered, reads stall, and oDone slips by exactly S cycles.
- oWindowValid is a pure function of the head tags; the first assertion is at pixel (2,2), beat index 2*IMG_W+2.
- oMemRdEn is never asserted outside STREAM.

## Test plan
- Reset, then iStart with iBaseAddr=0, iReady=1, and RAM[k]=k[7:0]:
  - 784 beats, oPixelOut = k mod 256, and tags (k/28, k%28).
  - oPixelValid first high at T+3.
  - oPixelLast only at beat 783, oDone at T+787.
  - oFrameCnt goes to 1.
  - Window-complete: first oWindowValid at beat 58 (2,2); 676 beats total have oWindowValid=1.
- Backpressure: iReady toggled by a random pattern (≈50%).
  - Sequence is identical to the first test, with no lost or duplicated beats.
  - Head data is stable across every stalled cycle.
  - oMemRdEn never leaves more than 2 pixels buffered.
- Wrap: iBaseAddr=1000, ADDR_W=10 → oMemAddr runs 1000…1023, then 0…759.
- Start while busy: iStart pulsed at beat 100 is ignored; iBaseAddr is unchanged and oFrameCnt increments by 1 only.
- Mid-frame reset: iRst for 1 cycle at beat 300.
  - All outputs are 0 the next cycle and oFrameCnt=0.
  - A subsequent iStart streams a full correct frame.
- Back-to-back frames: iStart issued in the oDone cycle+1.
  - The second frame starts 3 cycles later with correct tags.
  - oFrameCnt=2.
